hera_regf_lq: RTL and testbench

Parametrised next-generation HERA register file with a multi-entry outstanding-load queue replacing the single pending-load slot. Loads retire in order, with same-cycle forwarding to both read ports and a per-port hazard stall output. It keeps the R13–R15 call/return window shift and the multiply high-word path. It sits between decode, ALU and the data-memory response path in the joint HERA core.

---
 rtl/hera_regf_lq.sv | 141 ++++++++++++++
 tb/tb_hera_regf_lq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hera_regf_lq.sv
// hera_regf_lq: HERA register file with in-order outstanding-load queue, forwarding, window shift and mul high-word path
module hera_regf_lq #(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int LQ_DEPTH = 2,
  parameter int WIN_BASE = 13
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AW-1:0]                   rsa,
  input  logic [AW-1:0]                   rsb,
  input  logic [AW-1:0]                   rd,
  input  logic                            wr_en,
  input  logic [DW-1:0]                   wr_data,
  input  logic                            mul_en,
  input  logic [DW-1:0]                   mul_hi,
  input  logic                            ld_issue,
  output logic                            ld_rdy,
  input  logic                            ld_ret,
  input  logic [DW-1:0]                   ld_data,
  input  logic                            call_en,
  input  logic                            ret_en,
  input  logic [DW-1:0]                   call_inc,
  input  logic [DW-1:0]                   ret_data,
  output logic [DW-1:0]                   rsa_data,
  output logic [DW-1:0]                   rsb_data,
  output logic                            stall_a,
  output logic                            stall_b,
  output logic [2:0]                      load_flags,
  output logic [$clog2(LQ_DEPTH+1)-1:0]   lq_count,
  output logic                            lq_ovf
);
  localparam int NREGS = 2**AW;
  localparam int CW    = $clog2(LQ_DEPTH+1);
  localparam int PW    = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int W0    = WIN_BASE;
  localparam int W1    = WIN_BASE + 1;
  localparam int W2    = WIN_BASE + 2;

  if (WIN_BASE + 2 >= NREGS || WIN_BASE < 1) begin : g_bad_win
    $error("hera_regf_lq: WIN_BASE window does not fit the register file");
  end
  if (LQ_DEPTH < 1 || (LQ_DEPTH & (LQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hera_regf_lq: LQ_DEPTH must be a power of two >= 1");
  end

  logic [DW-1:0]       regs_q [NREGS];
  logic [DW-1:0]       regs_d [NREGS];
  logic [AW-1:0]       tags_q [LQ_DEPTH];
  logic [AW-1:0]       tags_d [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] vld_q, vld_d, live;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                ret, issue_ok;
  logic [AW-1:0]       head_tag;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    nxt = (p == PW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_tag   = tags_q[head_q];
  assign ret        = ld_ret & (count_q != '0);
  assign ld_rdy     = (count_q < CW'(LQ_DEPTH)) | ld_ret;
  assign issue_ok   = ld_issue & ld_rdy;
  assign rsa_data   = (ret && head_tag == rsa && rsa != '0) ? ld_data : regs_q[rsa];
  assign rsb_data   = (ret && head_tag == rsb && rsb != '0) ? ld_data : regs_q[rsb];
  assign load_flags = ret ? {1'b1, ld_data[DW-1], |ld_data} : 3'b000;
  assign lq_count   = count_q;
  assign lq_ovf     = ovf_q;

  // hazard detect: any queued load still pending after this cycle's retire
  always_comb begin
    live    = '0;
    stall_a = 1'b0;
    stall_b = 1'b0;
    for (int j = 0; j < LQ_DEPTH; j++) begin
      live[j] = vld_q[j] && !(ret && PW'(j) == head_q);
      stall_a = stall_a | (live[j] && tags_q[j] == rsa && rsa != '0);
      stall_b = stall_b | (live[j] && tags_q[j] == rsb && rsb != '0);
    end
  end

  // register next state; later assignments take priority: shift < retire < alu < mul, R0 pinned
  always_comb begin
    regs_d = regs_q;
    if (call_en) begin
      regs_d[W0] = regs_q[W1];
      regs_d[W1] = regs_q[W2];
      regs_d[W2] = regs_q[W2] + call_inc;
    end else if (ret_en) begin
      regs_d[W2] = regs_q[W1];
      regs_d[W1] = regs_q[W0];
      regs_d[W0] = ret_data;
    end
    if (ret) regs_d[head_tag] = ld_data;
    if (wr_en) regs_d[rd] = wr_data;
    if (mul_en) regs_d[W0] = mul_hi;
    regs_d[0] = '0;
  end

  // load queue: pop head on retire, then push tail so issue+retire at full reuses the slot
  always_comb begin
    tags_d = tags_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (ret) begin
      vld_d[head_q] = 1'b0;
      head_d        = nxt(head_q);
    end
    if (issue_ok) begin
      tags_d[tail_q] = rd;
      vld_d[tail_q]  = 1'b1;
      tail_d         = nxt(tail_q);
    end
    count_d = count_q + CW'(issue_ok) - CW'(ret);
    ovf_d   = ovf_q | (ld_issue & ~ld_rdy);
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q  <= '{default: '0};
      tags_q  <= '{default: '0};
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      tags_q  <= tags_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_hera_regf_lq.sv
// tb_hera_regf_lq: directed bench with a queue-based reference model checked every cycle
module tb_hera_regf_lq;
  localparam int LQ = 2;
  localparam int WB = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rsa, rsb, rd;
  logic        wr_en, mul_en, ld_issue, ld_ret, call_en, ret_en;
  logic [15:0] wr_data, mul_hi, ld_data, call_inc, ret_data;
  logic        ld_rdy, stall_a, stall_b, lq_ovf;
  logic [15:0] rsa_data, rsb_data;
  logic [2:0]  load_flags;
  logic [1:0]  lq_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_r [16];
  int          q [$];
  bit          m_ovf;

  hera_regf_lq #(.DW(16), .AW(4), .LQ_DEPTH(LQ), .WIN_BASE(WB)) dut (
    .clk(clk), .rst(rst), .rsa(rsa), .rsb(rsb), .rd(rd),
    .wr_en(wr_en), .wr_data(wr_data), .mul_en(mul_en), .mul_hi(mul_hi),
    .ld_issue(ld_issue), .ld_rdy(ld_rdy), .ld_ret(ld_ret), .ld_data(ld_data),
    .call_en(call_en), .ret_en(ret_en), .call_inc(call_inc), .ret_data(ret_data),
    .rsa_data(rsa_data), .rsb_data(rsb_data), .stall_a(stall_a), .stall_b(stall_b),
    .load_flags(load_flags), .lq_count(lq_count), .lq_ovf(lq_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_retiring();
    return ld_ret && q.size() > 0;
  endfunction

  function automatic logic [15:0] e_read(input logic [3:0] a);
    if (a == 0) return 16'h0;
    if (m_retiring() && q[0] == int'(a)) return ld_data;
    return m_r[a];
  endfunction

  function automatic bit e_stall(input logic [3:0] a);
    if (a == 0) return 1'b0;
    for (int k = m_retiring() ? 1 : 0; k < q.size(); k++)
      if (q[k] == int'(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    q.delete();
    m_ovf = 1'b0;
  endfunction

  function automatic void m_step();
    logic [15:0] o [16];
    logic [15:0] nr [16];
    bit          w [16];
    bit          rdy;
    int          t;
    o   = m_r;
    nr  = m_r;
    w   = '{default: 1'b0};
    rdy = q.size() < LQ || ld_ret;
    if (wr_en && rd != 0) begin nr[rd] = wr_data; w[rd] = 1'b1; end
    if (mul_en) begin nr[WB] = mul_hi; w[WB] = 1'b1; end
    if (m_retiring()) begin
      t = q.pop_front();
      if (t != 0 && !w[t]) begin nr[t] = ld_data; w[t] = 1'b1; end
    end
    if (call_en) begin
      if (!w[WB])   nr[WB]   = o[WB+1];
      if (!w[WB+1]) nr[WB+1] = o[WB+2];
      if (!w[WB+2]) nr[WB+2] = o[WB+2] + call_inc;
    end else if (ret_en) begin
      if (!w[WB+2]) nr[WB+2] = o[WB+1];
      if (!w[WB+1]) nr[WB+1] = o[WB];
      if (!w[WB])   nr[WB]   = ret_data;
    end
    if (ld_issue) begin
      if (rdy) q.push_back(int'(rd));
      else m_ovf = 1'b1;
    end
    m_r = nr;
  endfunction

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_clear();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("rsa_data", rsa_data, e_read(rsa));
      chk("rsb_data", rsb_data, e_read(rsb));
      chk("stall_a", stall_a, e_stall(rsa));
      chk("stall_b", stall_b, e_stall(rsb));
      chk("ld_rdy", ld_rdy, (q.size() < LQ) || ld_ret);
      chk("load_flags", load_flags, m_retiring() ? {1'b1, ld_data[15], |ld_data} : 3'b000);
      chk("lq_count", lq_count, q.size());
      chk("lq_ovf", lq_ovf, m_ovf);
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
    rsa = 0; rsb = 0; rd = 0;
    wr_en = 0; mul_en = 0; ld_issue = 0; ld_ret = 0; call_en = 0; ret_en = 0;
    wr_data = 0; mul_hi = 0; ld_data = 0; call_inc = 0; ret_data = 0;
  endtask

  initial begin
    rst = 1'b0;
    nx();
    nx();
    rst = 1'b1;
    chk("reset_count", lq_count, 2'd0);
    chk("reset_ovf", lq_ovf, 1'b0);
    nx();
    ld_issue = 1; rd = 3;
    nx();
    ld_issue = 1; rd = 5;
    nx();
    #1 chk("mid_count", lq_count, 2'd2);
    rst = 1'b0;
    rsa = 3;
    #1 chk("rst_count", lq_count, 2'd0);
    chk("rst_rdy", ld_rdy, 1'b1);
    chk("rst_read", rsa_data, 16'h0);
    nx();
    rst = 1'b1;
    ld_ret = 1; ld_data = 16'h7777; rsa = 3;
    #1 chk("empty_ret_flags", load_flags, 3'b000);
    chk("empty_ret_read", rsa_data, 16'h0);
    nx();
    rsa = 3;
    #1 chk("empty_ret_nowrite", rsa_data, 16'h0);

    nx(); ld_issue = 1; rd = 3;
    nx(); ld_issue = 1; rd = 5;
    nx(); rsa = 5;
    #1 chk("stall_pending", stall_a, 1'b1);
    nx(); rsa = 5; ld_ret = 1; ld_data = 16'h8001;
    #1 chk("flags_8001", load_flags, 3'b111);
    chk("stall_second", stall_a, 1'b1);
    nx(); rsa = 3; rsb = 5;
    #1 chk("r3_8001", rsa_data, 16'h8001);
    chk("stall_b_r5", stall_b, 1'b1);
    nx(); rsa = 5; ld_ret = 1; ld_data = 16'h0000;
    #1 chk("flags_zero", load_flags, 3'b100);
    chk("stall_clear", stall_a, 1'b0);
    nx(); rsa = 5;
    #1 chk("r5_zero", rsa_data, 16'h0);
    chk("drained", lq_count, 2'd0);

    nx(); ld_issue = 1; rd = 7;
    nx(); ld_ret = 1; ld_data = 16'h1234; rsa = 7; rsb = 7;
    #1 chk("fwd_a", rsa_data, 16'h1234);
    chk("fwd_b", rsb_data, 16'h1234);
    chk("fwd_stall_a", stall_a, 1'b0);
    chk("fwd_stall_b", stall_b, 1'b0);

    nx(); ld_issue = 1; rd = 1;
    nx(); ld_issue = 1; rd = 2;
    nx(); ld_issue = 1; rd = 6;
    #1 chk("full_rdy", ld_rdy, 1'b0);
    nx();
    #1 chk("full_count", lq_count, 2'd2);
    chk("ovf_set", lq_ovf, 1'b1);
    nx(); ld_issue = 1; rd = 8; ld_ret = 1; ld_data = 16'h0011;
    #1 chk("full_ret_rdy", ld_rdy, 1'b1);
    nx();
    #1 chk("full_swap_count", lq_count, 2'd2);
    nx(); ld_ret = 1; ld_data = 16'h0022;
    nx(); ld_ret = 1; ld_data = 16'h0088;
    nx(); rsa = 1; rsb = 8;
    #1 chk("r1_11", rsa_data, 16'h0011);
    chk("r8_88", rsb_data, 16'h0088);
    nx(); rsa = 6;
    #1 chk("r6_dropped", rsa_data, 16'h0);

    nx(); ld_issue = 1; rd = 4;
    nx(); ld_ret = 1; ld_data = 16'hAAAA; wr_en = 1; rd = 4; wr_data = 16'h5555;
    nx(); rsa = 4;
    #1 chk("collision", rsa_data, 16'h5555);
    chk("collision_pop", lq_count, 2'd0);

    nx(); wr_en = 1; rd = 13; wr_data = 16'h0001;
    nx(); wr_en = 1; rd = 14; wr_data = 16'h0002;
    nx(); wr_en = 1; rd = 15; wr_data = 16'hFFFF;
    nx(); call_en = 1; call_inc = 16'h0002;
    nx(); rsa = 13; rsb = 14;
    #1 chk("call_w0", rsa_data, 16'h0002);
    chk("call_w1", rsb_data, 16'hFFFF);
    nx(); rsa = 15; ret_en = 1; ret_data = 16'h0009;
    #1 chk("call_w2", rsa_data, 16'h0001);
    nx(); rsa = 13; rsb = 14;
    #1 chk("ret_w0", rsa_data, 16'h0009);
    chk("ret_w1", rsb_data, 16'h0002);
    nx(); rsa = 15;
    #1 chk("ret_w2", rsa_data, 16'hFFFF);

    nx(); ld_issue = 1; rd = 13;
    nx(); ld_ret = 1; ld_data = 16'h3333; mul_en = 1; mul_hi = 16'h4444;
    wr_en = 1; rd = 13; wr_data = 16'h5555; call_en = 1; call_inc = 16'h0001;
    nx(); rsa = 13; rsb = 15;
    #1 chk("mul_wins", rsa_data, 16'h4444);
    chk("mix_w2", rsb_data, 16'h0000);
    nx(); ld_issue = 1; rd = 14;
    nx(); ld_ret = 1; ld_data = 16'h6666; call_en = 1; ret_en = 1; ret_data = 16'h0123;
    nx(); rsa = 13; rsb = 14;
    #1 chk("call_over_ret", rsa_data, 16'hFFFF);
    chk("retire_over_shift", rsb_data, 16'h6666);

    nx(); wr_en = 1; rd = 0; wr_data = 16'hBEEF; ld_issue = 1;
    nx(); rsa = 0;
    #1 chk("r0_write", rsa_data, 16'h0);
    chk("r0_slot", lq_count, 2'd1);
    nx(); rsa = 0; ld_ret = 1; ld_data = 16'h5A5A;
    #1 chk("r0_nofwd", rsa_data, 16'h0);
    chk("r0_flags", load_flags, 3'b101);

    for (int i = 0; i < 16; i++) begin
      nx(); rsa = 4'(i); rsb = 4'(15 - i);
    end
    nx();
    nx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
